// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with a word-organised data RAM and the
// MEM/WB pipeline register. Stores use byte enables built from the access
// size and byte offset; loads return the addressed word shifted down so the
// selected byte/halfword lands in the low bits. A halt captured into MEM/WB
// freezes the stage (register and RAM) until reset.
module mem_stage #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_REGS = 5,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_step,
  input  logic [BITS_SIZE-1:0]         i_exmem_alu,
  input  logic [BITS_SIZE-1:0]         i_exmem_data_write,
  input  logic                         i_exmem_mem_read,
  input  logic                         i_exmem_mem_write,
  input  logic [1:0]                   i_exmem_size,
  input  logic                         i_exmem_zero_extend,
  input  logic                         i_exmem_mem_to_reg,
  input  logic                         i_exmem_lui,
  input  logic                         i_exmem_jal,
  input  logic                         i_exmem_reg_write,
  input  logic                         i_exmem_halt,
  input  logic [BITS_SIZE-1:0]         i_exmem_extension,
  input  logic [BITS_SIZE-1:0]         i_exmem_pc8,
  input  logic [BITS_REGS-1:0]         i_exmem_register_dst,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0]         o_memwb_dato_mem,
  output logic [BITS_SIZE-1:0]         o_memwb_alu,
  output logic [BITS_SIZE-1:0]         o_memwb_extension,
  output logic [BITS_SIZE-1:0]         o_memwb_pc8,
  output logic [BITS_REGS-1:0]         o_memwb_register_dst,
  output logic [1:0]                   o_ctl_dataload_size,
  output logic                         o_memwb_zero_extend,
  output logic                         o_memwb_mem_to_reg,
  output logic                         o_memwb_lui,
  output logic                         o_memwb_jal,
  output logic                         o_memwb_reg_write,
  output logic                         o_memwb_halt,
  output logic                         o_misaligned,
  output logic [BITS_SIZE-1:0]         o_debug_data
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int NB = BITS_SIZE / 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e state_q, state_d;

  // Data RAM (not reset)
  logic [BITS_SIZE-1:0] mem_q [MEM_DEPTH];

  // Address decode and access classification
  logic [AW-1:0]        word_idx_s;
  logic [1:0]           off_s;
  logic                 misaligned_s;
  logic                 capture_s;
  logic                 wr_en_s;
  logic [NB-1:0]        be_s;
  logic [BITS_SIZE-1:0] lane_data_s;
  logic [BITS_SIZE-1:0] rd_word_s;
  logic [BITS_SIZE-1:0] load_data_s;

  // MEM/WB register state and next-state
  logic [BITS_SIZE-1:0] dato_q, dato_d;
  logic [BITS_SIZE-1:0] alu_q, alu_d;
  logic [BITS_SIZE-1:0] ext_q, ext_d;
  logic [BITS_SIZE-1:0] pc8_q, pc8_d;
  logic [BITS_REGS-1:0] dst_q, dst_d;
  logic [1:0]           size_q, size_d;
  logic                 zext_q, zext_d;
  logic                 m2r_q, m2r_d;
  logic                 lui_q, lui_d;
  logic                 jal_q, jal_d;
  logic                 rw_q, rw_d;
  logic                 halt_q, halt_d;
  logic                 mis_q, mis_d;

  assign word_idx_s = i_exmem_alu[AW+1:2];
  assign off_s      = i_exmem_alu[1:0];

  // The stage only advances when stepping and not frozen by a captured halt
  assign capture_s = i_step & (state_q != ST_HALTED);
  assign wr_en_s   = capture_s & i_exmem_mem_write & ~misaligned_s;

  // Alignment check from access size and byte offset
  always_comb begin
    misaligned_s = 1'b0;
    case (i_exmem_size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = off_s[0];
      default: misaligned_s = |off_s;
    endcase
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_s        = {NB{1'b0}};
    lane_data_s = i_exmem_data_write;
    case (i_exmem_size)
      2'b00: begin
        be_s        = {{(NB-1){1'b0}}, 1'b1} << off_s;
        lane_data_s = {NB{i_exmem_data_write[7:0]}};
      end
      2'b01: begin
        be_s        = {{(NB-2){1'b0}}, 2'b11} << off_s;
        lane_data_s = {(NB/2){i_exmem_data_write[15:0]}};
      end
      default: begin
        be_s        = {NB{1'b1}};
        lane_data_s = i_exmem_data_write;
      end
    endcase
  end

  // RAM write port: per-lane update, unaddressed lanes keep their contents
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NB; k++) begin
        if (be_s[k]) begin
          mem_q[word_idx_s][8*k +: 8] <= lane_data_s[8*k +: 8];
        end
      end
    end
  end

  // Combinational reads (pre-edge contents for the load path)
  assign rd_word_s    = mem_q[word_idx_s];
  assign o_debug_data = mem_q[i_debug_addr];

  // Load data: shift the addressed lane down; zero for misaligned or non-loads
  always_comb begin
    if (i_exmem_mem_read && !misaligned_s) begin
      load_data_s = rd_word_s >> {off_s, 3'b000};
    end else begin
      load_data_s = {BITS_SIZE{1'b0}};
    end
  end

  // Stage mode next-state: halted is terminal until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: state_d = ST_HALTED;
      default: begin
        if (i_step && i_exmem_halt) begin
          state_d = ST_HALTED;
        end else if (i_step) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
    endcase
  end

  // Stage mode register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // MEM/WB next-state: capture in RUN, otherwise hold
  always_comb begin
    dato_d = dato_q;
    alu_d  = alu_q;
    ext_d  = ext_q;
    pc8_d  = pc8_q;
    dst_d  = dst_q;
    size_d = size_q;
    zext_d = zext_q;
    m2r_d  = m2r_q;
    lui_d  = lui_q;
    jal_d  = jal_q;
    rw_d   = rw_q;
    halt_d = halt_q;
    if (capture_s) begin
      dato_d = load_data_s;
      alu_d  = i_exmem_alu;
      ext_d  = i_exmem_extension;
      pc8_d  = i_exmem_pc8;
      dst_d  = i_exmem_register_dst;
      size_d = i_exmem_size;
      zext_d = i_exmem_zero_extend;
      m2r_d  = i_exmem_mem_to_reg;
      lui_d  = i_exmem_lui;
      jal_d  = i_exmem_jal;
      // A misaligned load must not write back garbage
      rw_d   = i_exmem_reg_write & ~(i_exmem_mem_read & misaligned_s);
      halt_d = i_exmem_halt;
    end else begin
      halt_d = halt_q;
    end
  end

  // Sticky misaligned flag: set by any stepped misaligned memory access
  always_comb begin
    if (i_step && (i_exmem_mem_read || i_exmem_mem_write) && misaligned_s) begin
      mis_d = 1'b1;
    end else begin
      mis_d = mis_q;
    end
  end

  // MEM/WB register with asynchronous clear
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dato_q <= '0;
      alu_q  <= '0;
      ext_q  <= '0;
      pc8_q  <= '0;
      dst_q  <= '0;
      size_q <= 2'b00;
      zext_q <= 1'b0;
      m2r_q  <= 1'b0;
      lui_q  <= 1'b0;
      jal_q  <= 1'b0;
      rw_q   <= 1'b0;
      halt_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      dato_q <= dato_d;
      alu_q  <= alu_d;
      ext_q  <= ext_d;
      pc8_q  <= pc8_d;
      dst_q  <= dst_d;
      size_q <= size_d;
      zext_q <= zext_d;
      m2r_q  <= m2r_d;
      lui_q  <= lui_d;
      jal_q  <= jal_d;
      rw_q   <= rw_d;
      halt_q <= halt_d;
      mis_q  <= mis_d;
    end
  end

  assign o_memwb_dato_mem     = dato_q;
  assign o_memwb_alu          = alu_q;
  assign o_memwb_extension    = ext_q;
  assign o_memwb_pc8          = pc8_q;
  assign o_memwb_register_dst = dst_q;
  assign o_ctl_dataload_size  = size_q;
  assign o_memwb_zero_extend  = zext_q;
  assign o_memwb_mem_to_reg   = m2r_q;
  assign o_memwb_lui          = lui_q;
  assign o_memwb_jal          = jal_q;
  assign o_memwb_reg_write    = rw_q;
  assign o_memwb_halt         = halt_q;
  assign o_misaligned         = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected MEM/WB
// image for every stepped instruction; a monitor pops and compares one
// cycle-image after each stepped rising edge.
module tb_mem_stage;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic [31:0] alu_i, wdata_i, ext_i, pc8_i;
  logic        rd_i, wr_i, zext_i, m2r_i, lui_i, jal_i, rw_i, halt_i;
  logic [1:0]  size_i;
  logic [4:0]  dst_i;
  logic [AW-1:0] dbg_addr;

  logic [31:0] dato_o, alu_o, ext_o, pc8_o, dbg_o;
  logic [4:0]  dst_o;
  logic [1:0]  size_o;
  logic        zext_o, m2r_o, lui_o, jal_o, rw_o, halt_o, mis_o;

  typedef logic [141:0] vec_t;
  vec_t act_vec;
  vec_t exp_q[$];
  vec_t last_exp;
  vec_t mon_e;
  bit   halted;
  bit   mis_sticky;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.BITS_SIZE(32), .BITS_REGS(5), .MEM_DEPTH(256)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_step(step),
    .i_exmem_alu(alu_i), .i_exmem_data_write(wdata_i),
    .i_exmem_mem_read(rd_i), .i_exmem_mem_write(wr_i), .i_exmem_size(size_i),
    .i_exmem_zero_extend(zext_i), .i_exmem_mem_to_reg(m2r_i),
    .i_exmem_lui(lui_i), .i_exmem_jal(jal_i), .i_exmem_reg_write(rw_i),
    .i_exmem_halt(halt_i), .i_exmem_extension(ext_i), .i_exmem_pc8(pc8_i),
    .i_exmem_register_dst(dst_i), .i_debug_addr(dbg_addr),
    .o_memwb_dato_mem(dato_o), .o_memwb_alu(alu_o),
    .o_memwb_extension(ext_o), .o_memwb_pc8(pc8_o),
    .o_memwb_register_dst(dst_o), .o_ctl_dataload_size(size_o),
    .o_memwb_zero_extend(zext_o), .o_memwb_mem_to_reg(m2r_o),
    .o_memwb_lui(lui_o), .o_memwb_jal(jal_o), .o_memwb_reg_write(rw_o),
    .o_memwb_halt(halt_o), .o_misaligned(mis_o), .o_debug_data(dbg_o)
  );

  assign act_vec = {dato_o, alu_o, ext_o, pc8_o, dst_o, size_o,
                    zext_o, m2r_o, lui_o, jal_o, rw_o, halt_o, mis_o};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one stepped instruction and push its expected MEM/WB image
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [1:0] sz,
                       input logic rw, input logic hlt,
                       input logic [31:0] exp_dato, input bit misal);
    logic [31:0] ext_v, pc8_v;
    ext_v = a ^ 32'h0F0F_0F0F;
    pc8_v = a + 32'd8;
    @(negedge clk);
    step = 1'b1; alu_i = a; wdata_i = wd; rd_i = rd; wr_i = wr; size_i = sz;
    zext_i = a[0]; m2r_i = rd; lui_i = a[1]; jal_i = a[2]; rw_i = rw;
    halt_i = hlt; ext_i = ext_v; pc8_i = pc8_v; dst_i = a[4:0];
    if (!halted) begin
      if (misal) mis_sticky = 1'b1;
      last_exp = {exp_dato, a, ext_v, pc8_v, a[4:0], sz, a[0], rd, a[1], a[2],
                  rw & ~(rd & misal), hlt, mis_sticky};
      if (hlt) halted = 1'b1;
    end
    exp_q.push_back(last_exp);
  endtask

  task automatic idle();
    @(negedge clk);
    step = 1'b0; rd_i = 1'b0; wr_i = 1'b0; halt_i = 1'b0;
  endtask

  // Asynchronous reset pulse between edges with nonzero inputs applied
  task automatic reset_pulse();
    @(negedge clk);
    step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", act_vec);
    end
    #1 rst_n = 1'b1;
    halted = 1'b0;
    mis_sticky = 1'b0;
  endtask

  // Monitor: compare the registered outputs after every stepped edge
  always @(posedge clk) begin
    if (rst_n && step) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL memwb_unexpected: got %h expected none", act_vec);
      end else begin
        mon_e = exp_q.pop_front();
        if (act_vec !== mon_e) begin
          errors++;
          $display("FAIL memwb: got %h expected %h", act_vec, mon_e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; step = 1'b0; alu_i = '0; wdata_i = '0; ext_i = '0; pc8_i = '0;
    rd_i = 1'b0; wr_i = 1'b0; zext_i = 1'b0; m2r_i = 1'b0; lui_i = 1'b0;
    jal_i = 1'b0; rw_i = 1'b0; halt_i = 1'b0; size_i = 2'b00; dst_i = '0;
    dbg_addr = 8'd4; halted = 1'b0; mis_sticky = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", act_vec);
    end
    rst_n = 1'b1;

    // Reset: load outputs with nonzero values (misaligned store + halt), then clear
    issue(32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0, 1'b1);
    idle();
    reset_pulse();

    // Word store/load
    issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0010, 32'h0,        1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    idle();
    check32("debug_word4", dbg_o, 32'hDEAD_BEEF);

    // Byte and halfword lanes
    issue(32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0011, 32'hCCCC_CC55, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0012, 32'hDDDD_A1B2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0011, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00A1_B255, 1'b0);
    issue(32'h0000_0012, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_A1B2, 1'b0);
    idle();
    check32("debug_lanes", dbg_o, 32'hA1B2_5500);

    // Misaligned store then misaligned halfword load
    issue(32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(32'h0000_0011, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1);
    idle();
    check32("misaligned_ram_unchanged", dbg_o, 32'hA1B2_5500);
    check32("misaligned_flag", {31'd0, mis_o}, 32'd1);

    // Stall: preset word 8, leave a distinct instruction in MEM/WB
    issue(32'h0000_0020, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'hA1B2_5500, 1'b0);
    idle();
    dbg_addr = 8'd8;
    alu_i = 32'h0000_0020; wdata_i = 32'h0000_1234; wr_i = 1'b1; size_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("stall_ram", dbg_o, 32'h0);
      check32("stall_alu", alu_o, 32'h0000_0010);
      check32("stall_dato", dato_o, 32'hA1B2_5500);
    end
    issue(32'h0000_0020, 32'h0000_1234, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    check32("stall_release", dbg_o, 32'h0000_1234);

    // Halt: later stores ignored, outputs frozen
    issue(32'h0000_0040, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0);
    issue(32'h0000_0020, 32'h0000_5555, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0020, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    idle();
    check32("halt_ram_frozen", dbg_o, 32'h0000_1234);
    reset_pulse();
    check32("reset_keeps_ram", dbg_o, 32'h0000_1234);
    check32("reset_clears_mis", {31'd0, mis_o}, 32'd0);

    // Stage runs again after reset
    issue(32'h0000_0020, 32'h0000_0077, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(32'h0000_0020, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_0077, 1'b0);
    idle();
    check32("post_reset_store", dbg_o, 32'h0000_0077);

    repeat (2) @(negedge clk);
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

MIPS pipeline memory-access stage with integrated data memory and MEM/WB pipeline register. It consumes the EX/MEM latch outputs and performs byte-, halfword- and word-sized stores and loads against a word-organised data RAM. It registers everything the write-back stage consumes (`o_memwb_*`) on each enabled clock. A debug port lets the debug unit inspect RAM, and a halt flag is propagated so the debug unit can detect program end.

## Interface
- `BITS_SIZE`, 32, datapath width
- `BITS_REGS`, 5, register-index width
- `MEM_DEPTH`, 256, data RAM depth in words (power of two)
- `i_clk` in 1 system clock, rising edge
- `i_reset` in 1 reset, asynchronous, active-low
- `i_step` in 1 pipeline advance enable from debug unit; 0 freezes stage
- `i_exmem_alu` in BITS_SIZE ALU result; byte address for loads and stores
- `i_exmem_data_write` in BITS_SIZE store data (rt)
- `i_exmem_mem_read` in 1 load instruction
- `i_exmem_mem_write` in 1 store instruction
- `i_exmem_size` in 2 access size: 00 byte, 01 halfword, 1x word
- `i_exmem_zero_extend` / `i_exmem_mem_to_reg` / `i_exmem_lui` / `i_exmem_jal` / `i_exmem_reg_write` / `i_exmem_halt` in 1 each control bits passed to WB
- `i_exmem_extension` in BITS_SIZE, `i_exmem_pc8` in BITS_SIZE, `i_exmem_register_dst` in BITS_REGS passed to WB
- `i_debug_addr` in $clog2(MEM_DEPTH) word address for debug read
- `o_memwb_dato_mem` out BITS_SIZE aligned load data
- `o_memwb_alu`, `o_memwb_extension`, `o_memwb_pc8` out BITS_SIZE registered copies
- `o_memwb_register_dst` out BITS_REGS
- `o_ctl_dataload_size` out 2 registered `i_exmem_size`
- `o_memwb_zero_extend`, `o_memwb_mem_to_reg`, `o_memwb_lui`, `o_memwb_jal`, `o_memwb_reg_write`, `o_memwb_halt` out 1
- `o_misaligned` out 1 sticky misaligned-access flag
- `o_debug_data` out BITS_SIZE combinational RAM word at `i_debug_addr`

## Operation
- Word index = `i_exmem_alu[$clog2(MEM_DEPTH)+1:2]`, byte offset `off` = `i_exmem_alu[1:0]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- **Alignment:**
  - Byte accesses are always aligned.
  - Halfword accesses are aligned when `off[0]`=0.
  - Word accesses are aligned when `off`=00.
- **Store** (`mem_write`, aligned, `i_step`=1):
  - Byte: `data_write[7:0]` is written to byte lane `off`.
  - Halfword: `data_write[15:0]` is written to lanes {off+1,off}.
  - Word: all four lanes are written.
  - Lanes not addressed keep their contents.
  - Lane 0 = bits [7:0] (little-endian).
- **Load:**
  - The RAM word is read combinationally and shifted right by 8·`off`, so the addressed byte or halfword lands in bits [7:0] or [15:0].
  - The upper bits keep the shifted raw word. Sign or zero extension is done downstream using `o_ctl_dataload_size` and `o_memwb_zero_extend`.
  - For a misaligned load, `o_memwb_dato_mem` is 0.
- **Non-memory instruction:** `o_memwb_dato_mem` is 0.
- **Misaligned access:**
  - A misaligned store is suppressed (no RAM write).
  - Any misaligned load or store with `i_step`=1 sets `o_misaligned`, which is cleared only by reset.
  - For a misaligned load, `o_memwb_reg_write` is forced to 0.
- **Halt freeze:**
  - Once `o_memwb_halt`=1, the MEM/WB register and the RAM are frozen regardless of `i_step`.
  - Only reset releases the freeze.
- **MEM/WB register states:**
  - RUN: `i_step`=1 and not halted → capture.
  - HOLD: `i_step`=0 → keep.
  - HALTED: `o_memwb_halt`=1 → keep; exit only via reset.
- The RAM is not reset. Its contents are undefined until written.

## Timing
- **Reset** (`i_reset`=0, asynchronous): every `o_memwb_*` output, `o_ctl_dataload_size` and `o_misaligned` go to 0 immediately and stay 0 while reset is asserted.
- **Latency:** EX/MEM inputs appear on `o_memwb_*` one rising edge after they are presented with `i_step`=1.
- **Store timing:** the RAM write happens on the same edge that captures the instruction into MEM/WB.
- **Store-then-load:** a load in the next enabled cycle sees the stored data.
- **Read-before-write:** the load path reads pre-edge RAM contents.
- **Debug read:** `o_debug_data` is combinational and reflects a store on the edge it completes.
- **Stall:** `i_step`=0 holds every registered output and performs no RAM write, even if `mem_write`=1.
- **Reset mid-stall or mid-halt:** outputs clear and the stage returns to RUN. RAM keeps its contents.

## Test plan
- **Reset:**
  - Stimulus: drive all inputs nonzero, pulse `i_reset` low between edges.
  - Required: all `o_memwb_*` = 0 and `o_misaligned` = 0 immediately (asynchronously), before the next clock edge.
- **Word store/load:**
  - Stimulus: SW 0xDEADBEEF to address 0x10, then LW from 0x10.
  - Required: `o_memwb_dato_mem` = 0xDEADBEEF one edge after the LW; `o_debug_data` at index 4 = 0xDEADBEEF.
- **Byte and halfword lanes:**
  - Stimulus: SB 0x55 to 0x11, then SH 0xA1B2 to 0x12 over word 0x00000000.
  - Required: word = 0xA1B25500; LB from 0x11 gives bits [7:0] = 0x55; LH from 0x12 gives bits [15:0] = 0xA1B2.
- **Misaligned accesses:**
  - Stimulus: SW to 0x13, then LH from 0x11.
  - Required: RAM unchanged, `o_misaligned` = 1, `o_memwb_reg_write` = 0, `o_memwb_dato_mem` = 0.
- **Stall:**
  - Stimulus: hold `i_step` = 0 for 3 cycles with SW 0x1234 to 0x20 presented.
  - Required: outputs unchanged and RAM word 8 unchanged; after `i_step` = 1, word 8 = 0x1234.
- **Halt:**
  - Stimulus: `i_exmem_halt` = 1 with `i_step` = 1, followed by a SW.
  - Required: `o_memwb_halt` = 1 after one edge; later SW stores are ignored and outputs are frozen until reset.
